// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: fetch-to-decode valid/ready handshake.
// Ports (signals):
//   out_valid  fetch buffer head is valid        (fetch -> decode)
//   out_ready  decode accepts the head           (decode -> fetch)
//   out_inst   32-bit head instruction           (fetch -> decode)
//   out_pc     64-bit byte address of the head   (fetch -> decode)
interface inst_fetch_unit_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    modport master (output out_valid, out_inst, out_pc, input out_ready);
    modport slave  (input out_valid, out_inst, out_pc, output out_ready);
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC sequencer feeding a 2-entry fetch buffer from a combinational-read memory.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start                        pulse; begin fetching from RESET_PC (IDLE or HALT)
//   Inst_Address / Instruction   memory address (the PC register) and same-cycle read data
//   redirect_valid, redirect_pc  taken branch/jump from execute; flushes the buffer
//   dec                          valid/ready handshake towards decode
//   busy, done, error            RUN state, HALT with empty buffer, sticky misaligned redirect
//   fetch_count                  buffer pushes since start, wraps mod 2^32
module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_BYTES = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic [63:0]              Inst_Address,
    input  logic [31:0]              Instruction,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    inst_fetch_unit_if.master        dec,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [31:0]              fetch_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALT, ERR} state_t;

    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES) - 64'd4;

    state_t      state, state_d;
    logic [63:0] pc, pc_d;
    logic [1:0]  count, count_d;
    logic        head, head_d;
    logic        error_d;
    logic [31:0] fetch_d;
    logic [63:0] buf_pc [2];
    logic [31:0] buf_inst [2];
    logic        push, pop, tail;

    // Two-slot ring: the free slot after the live entries is head+count (mod 2).
    // When full with a pop, that is the head slot, which is vacated on the same edge.
    assign tail = head ^ count[0];

    always_comb begin
        state_d = state;
        pc_d    = pc;
        count_d = count;
        head_d  = head;
        error_d = error;
        fetch_d = fetch_count;
        push    = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                    count_d = 2'd0;
                    head_d  = 1'b0;
                    fetch_d = 32'd0;
                end
            end
            RUN, HALT: begin
                if (redirect_valid) begin
                    // Redirect overrides push, pop and start; a misaligned target is fatal.
                    count_d = 2'd0;
                    if (redirect_pc[1:0] == 2'd0) begin
                        pc_d    = redirect_pc;
                        state_d = RUN;
                    end else begin
                        error_d = 1'b1;
                        state_d = ERR;
                    end
                end else if (state == HALT && start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                    count_d = 2'd0;
                    head_d  = 1'b0;
                    fetch_d = 32'd0;
                end else begin
                    pop = count != 2'd0 && dec.out_ready;
                    if (state == RUN && pc > LAST_PC)
                        state_d = HALT;
                    else if (state == RUN)
                        push = count != 2'd2 || pop;
                    head_d  = head ^ pop;
                    pc_d    = push ? pc + 64'd4 : pc;
                    fetch_d = fetch_count + 32'(push);
                    count_d = count + 2'(push) - 2'(pop);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            count       <= 2'd0;
            head        <= 1'b0;
            error       <= 1'b0;
            fetch_count <= 32'd0;
            buf_pc[0]   <= 64'd0;
            buf_pc[1]   <= 64'd0;
            buf_inst[0] <= 32'd0;
            buf_inst[1] <= 32'd0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            count       <= count_d;
            head        <= head_d;
            error       <= error_d;
            fetch_count <= fetch_d;
            if (push) begin
                buf_pc[tail]   <= pc;
                buf_inst[tail] <= Instruction;
            end
        end
    end

    assign Inst_Address  = pc;
    assign dec.out_valid = count != 2'd0;
    assign dec.out_inst  = buf_inst[head];
    assign dec.out_pc    = buf_pc[head];
    assign busy          = state == RUN;
    assign done          = state == HALT && count == 2'd0;
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Sequences the combinational-read, byte-addressed, little-endian instruction memory: owns the PC, drives the memory address, and captures each 32-bit instruction into a 2-entry fetch buffer.
- Hands instructions to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the buffer.
- Detects end-of-memory and misaligned redirect targets.

Parameters:
- RESET_PC, 0, byte address of the first fetch after start.
- MEM_BYTES, 1024, instruction memory size in bytes; legal fetch addresses are 0..MEM_BYTES-4.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins fetching from RESET_PC.
- Inst_Address  out  64  byte address to instruction memory; always equals the PC register.
- Instruction  in  32  memory read data for Inst_Address, valid in the same cycle.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  64  redirect target byte address.
- out_valid  out  1  buffer head is valid.
- out_ready  in  1  decode accepts the head.
- out_inst  out  32  head instruction.
- out_pc  out  64  head PC.
- busy  out  1  state is RUN.
- done  out  1  state is HALT and buffer is empty.
- error  out  1  sticky misaligned-redirect flag.
- fetch_count  out  32  number of buffer pushes since start; wraps mod 2^32.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - state=IDLE; pc=RESET_PC; buffer count=0.
  - out_valid=0, out_inst=0, out_pc=0.
  - busy=0, done=0, error=0, fetch_count=0.
- Reset asserted mid-operation aborts immediately; no partial push survives.
- States are IDLE, RUN, HALT, ERR.
- IDLE:
  - start=1 at an edge: pc<=RESET_PC, count<=0, fetch_count<=0, state<=RUN.
  - redirect_valid is ignored.
- RUN, push rule:
  - Push when count<2, or count==2 and a pop occurs in the same cycle.
  - A push writes {pc, Instruction} at the tail, sets pc<=pc+4, and increments fetch_count.
- RUN, end of memory:
  - If pc > MEM_BYTES-4, no push; state<=HALT; pc holds.
- Pop: out_valid && out_ready at an edge removes the head. Push and pop in the same cycle leave count unchanged and preserve order.
- Latency:
  - start sampled at edge N; first push at edge N+1; out_valid=1 after edge N+1 with out_pc=RESET_PC.
  - Steady-state throughput is 1 instruction/cycle while out_ready=1.
- Redirect (RUN or HALT), priority over push and pop:
  - If redirect_pc[1:0]==0: flush the buffer (count<=0), pc<=redirect_pc, no push or pop that cycle, state<=RUN. The target appears on out_pc after the following edge (2 edges after the redirect).
  - If redirect_pc[1:0]!=0: flush, error<=1, state<=ERR; pc unchanged.
- HALT:
  - No pushes; pops continue.
  - done=1 when count==0.
  - start restarts exactly as from IDLE.
- ERR:
  - No pushes; buffer stays empty; out_valid=0.
  - Leave only via reset.
  - start and redirect are ignored.
- Simultaneous start and redirect in HALT: redirect wins.
- Buffer full (count==2) with out_ready=0: pc and fetch_count hold; Inst_Address stable.
- out_inst/out_pc hold the last popped values while out_valid=0; they are don't-care for checking.
- Width rules:
  - pc+4 is 64-bit and wraps mod 2^64; the end-of-memory check prevents that in practice.
  - Inst_Address is driven directly from pc, with no combinational path from the inputs.

Test Plan:
- Sequential fetch: reset, start, out_ready=1, memory word k = 0x00100613+k -> out_pc 0,4,8,… on consecutive cycles with matching out_inst; first out_valid one edge after start; fetch_count increments each cycle.
- Backpressure: out_ready=0 for 5 cycles after start -> count saturates at 2; Inst_Address holds 8; out_pc stays 0. Then out_ready=1 -> outputs 0,4,8 in order with no loss or duplication.
- Redirect: after out_pc=0x10 is accepted, redirect_valid with redirect_pc=0x48 and buffer full -> buffer flushed; next out_valid (2 edges later) has out_pc=0x48; no stale 0x14/0x18 appears.
- Misaligned redirect: redirect_pc=0x4A -> error=1, out_valid=0, busy=0; a later start has no effect until reset_n pulses low, after which error=0 and state is IDLE.
- End of memory: MEM_BYTES=16, out_ready=1 -> exactly 4 instructions delivered (pc 0..12); fetch_count=4; done=1 after the last pop. A redirect to 0 then resumes RUN.
- Async reset mid-run: drop reset_n between edges while count=2 -> outputs clear immediately; Inst_Address=RESET_PC; no out_valid until a new start.
